// File: rtl/uart_rx_gen.sv
// uart_rx_gen: UART receiver, 5..9 data bits, none/even/odd parity, 1-2 stop bits; UART_RX_GEN_BREAK_DETECT_EN adds break_det.
// Latency: valid/flags one cycle after the final stop sample; no backpressure, each frame overwrites the held word.
module uart_rx_gen #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx_sync_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 valid,
   output logic                 frame_error,
   output logic                 parity_error,
   output logic                 busy,
`ifdef UART_RX_GEN_BREAK_DETECT_EN
   output logic                 break_det,
`endif
   output logic                 sample_tick
);

   localparam int TICKS_PER_BIT = CLK_HZ / BAUD;
   localparam int HALF_TICKS    = TICKS_PER_BIT / 2;
   localparam int CW            = $clog2(TICKS_PER_BIT + 1);

   localparam logic [CW-1:0] TICK_FULL     = CW'(TICKS_PER_BIT - 1);
   localparam logic [CW-1:0] TICK_HALF     = CW'(HALF_TICKS - 1);
   localparam logic [CW-1:0] TICK_ONE      = CW'(1);
   localparam logic [3:0]    BIT_DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    BIT_STOP_LAST = 4'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_gen: DATA_BITS must be in 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_rx_gen: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_gen: STOP_BITS must be 1 or 2");
   end
   if (TICKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_rx_gen: CLK_HZ/BAUD must be at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        tick_q, tick_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_acc_q, par_acc_d;
   logic                 par_fail_q, par_fail_d;
   logic                 stop_fail_q, stop_fail_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 sample;
`ifdef UART_RX_GEN_BREAK_DETECT_EN
   logic                 zero_q, zero_d;
   logic                 brk_q, brk_d;
   logic                 zero_first_stop;
`endif

   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      par_acc_d    = par_acc_q;
      par_fail_d   = par_fail_q;
      stop_fail_d  = stop_fail_q;
      rx_data_d    = rx_data_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      valid_d      = 1'b0;
      sample       = 1'b0;
`ifdef UART_RX_GEN_BREAK_DETECT_EN
      zero_d          = zero_q;
      brk_d           = 1'b0;
      zero_first_stop = zero_q;
`endif

      // One down-counter times every bit; it reloads on each sample.
      if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
         sample = (tick_q == '0);
         tick_d = sample ? TICK_FULL : tick_q - TICK_ONE;
      end

      unique case (state_q)
         S_IDLE: begin
            if (!rx_sync_in) begin
               state_d     = S_START;
               tick_d      = TICK_HALF;
               bit_d       = BIT_DATA_LAST;
               par_acc_d   = 1'b0;
               par_fail_d  = 1'b0;
               stop_fail_d = 1'b0;
`ifdef UART_RX_GEN_BREAK_DETECT_EN
               zero_d      = 1'b1;
`endif
            end
         end
         S_START: begin
            if (sample) begin
               state_d = rx_sync_in ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (sample) begin
               shift_d   = {rx_sync_in, shift_q[DATA_BITS-1:1]};
               par_acc_d = par_acc_q ^ rx_sync_in;
`ifdef UART_RX_GEN_BREAK_DETECT_EN
               zero_d    = zero_q & ~rx_sync_in;
`endif
               if (bit_q == '0) begin
                  bit_d   = BIT_STOP_LAST;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q - 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (sample) begin
               par_fail_d = (PARITY == 2) ? ~(par_acc_q ^ rx_sync_in)
                                          :  (par_acc_q ^ rx_sync_in);
`ifdef UART_RX_GEN_BREAK_DETECT_EN
               zero_d     = zero_q & ~rx_sync_in;
`endif
               state_d    = S_STOP;
            end
         end
         S_STOP: begin
            if (sample) begin
               stop_fail_d = stop_fail_q | ~rx_sync_in;
`ifdef UART_RX_GEN_BREAK_DETECT_EN
               if (bit_q == BIT_STOP_LAST) begin
                  zero_first_stop = zero_q & ~rx_sync_in;
               end
               zero_d = zero_first_stop;
`endif
               if (bit_q == '0) begin
                  valid_d      = 1'b1;
                  rx_data_d    = shift_q;
                  frame_err_d  = stop_fail_q | ~rx_sync_in;
                  parity_err_d = par_fail_q;
`ifdef UART_RX_GEN_BREAK_DETECT_EN
                  brk_d        = zero_first_stop;
`endif
                  // A low final stop may be a break; wait for the line to rise.
                  state_d      = rx_sync_in ? S_IDLE : S_WAIT_IDLE;
               end else begin
                  bit_d = bit_q - 4'd1;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (rx_sync_in) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         tick_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         par_acc_q    <= 1'b0;
         par_fail_q   <= 1'b0;
         stop_fail_q  <= 1'b0;
         rx_data_q    <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
`ifdef UART_RX_GEN_BREAK_DETECT_EN
         zero_q       <= 1'b0;
         brk_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         par_acc_q    <= par_acc_d;
         par_fail_q   <= par_fail_d;
         stop_fail_q  <= stop_fail_d;
         rx_data_q    <= rx_data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
`ifdef UART_RX_GEN_BREAK_DETECT_EN
         zero_q       <= zero_d;
         brk_q        <= brk_d;
`endif
      end
   end

   assign rx_data      = rx_data_q;
   assign valid        = valid_q;
   assign frame_error  = frame_err_q;
   assign parity_error = parity_err_q;
   assign busy         = (state_q != S_IDLE);
   assign sample_tick  = sample;
`ifdef UART_RX_GEN_BREAK_DETECT_EN
   assign break_det    = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_gen.sv
// Bench for uart_rx_gen: default, even-parity and 7N2 instances on separate lines, fed directed frames.
module tb_uart_rx_gen;

   localparam int T = 868;
   localparam int H = 434;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx0, rx1, rx2;
   logic [7:0] data0, data1;
   logic [6:0] data2;
   logic       valid0, valid1, valid2;
   logic       fe0, fe1, fe2;
   logic       pe0, pe1, pe2;
   logic       busy0, busy1, busy2;
   logic       st0, st1, st2;
`ifdef UART_RX_GEN_BREAK_DETECT_EN
   logic       brk0, brk1, brk2;
`endif

   int checks = 0;
   int errors = 0;
   int vcnt0 = 0, vcnt1 = 0, vcnt2 = 0;
   int brk_with_valid = 0, brk_any = 0;

   always #5 clk = ~clk;

   uart_rx_gen u_dut0 (
      .clk(clk), .reset_n(reset_n), .rx_sync_in(rx0), .rx_data(data0), .valid(valid0),
      .frame_error(fe0), .parity_error(pe0), .busy(busy0),
`ifdef UART_RX_GEN_BREAK_DETECT_EN
      .break_det(brk0),
`endif
      .sample_tick(st0));

   uart_rx_gen #(.PARITY(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .rx_sync_in(rx1), .rx_data(data1), .valid(valid1),
      .frame_error(fe1), .parity_error(pe1), .busy(busy1),
`ifdef UART_RX_GEN_BREAK_DETECT_EN
      .break_det(brk1),
`endif
      .sample_tick(st1));

   uart_rx_gen #(.DATA_BITS(7), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .rx_sync_in(rx2), .rx_data(data2), .valid(valid2),
      .frame_error(fe2), .parity_error(pe2), .busy(busy2),
`ifdef UART_RX_GEN_BREAK_DETECT_EN
      .break_det(brk2),
`endif
      .sample_tick(st2));

   always @(negedge clk) begin
      if (valid0 === 1'b1) vcnt0++;
      if (valid1 === 1'b1) vcnt1++;
      if (valid2 === 1'b1) vcnt2++;
`ifdef UART_RX_GEN_BREAK_DETECT_EN
      if (brk2 === 1'b1) begin
         brk_any++;
         if (valid2 === 1'b1) brk_with_valid++;
      end
`endif
   end

   typedef struct {
      int         dut;
      logic [8:0] data;
      int         nbits;
      bit         has_par;
      logic       par_bit;
      int         nstop;
      logic [8:0] exp_data;
      logic       exp_fe;
      logic       exp_pe;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input int w, input logic v);
      case (w)
         0:       rx0 = v;
         1:       rx1 = v;
         default: rx2 = v;
      endcase
   endtask

   task automatic hold(input int w, input logic v, input int n);
      drive(w, v);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input int w, input logic [8:0] d, input int nbits, input bit has_par,
                             input logic pbit, input int nstop, input logic sval);
      hold(w, 1'b0, T);
      for (int i = 0; i < nbits; i++) hold(w, d[i], T);
      if (has_par) hold(w, pbit, T);
      for (int i = 0; i < nstop; i++) hold(w, sval, T);
   endtask

   function automatic int out_data(input int w);
      case (w)
         0:       return int'(data0);
         1:       return int'(data1);
         default: return int'(data2);
      endcase
   endfunction

   function automatic int out_fe(input int w);
      case (w)
         0:       return int'(fe0);
         1:       return int'(fe1);
         default: return int'(fe2);
      endcase
   endfunction

   function automatic int out_pe(input int w);
      case (w)
         0:       return int'(pe0);
         1:       return int'(pe1);
         default: return int'(pe2);
      endcase
   endfunction

   function automatic int out_vcnt(input int w);
      case (w)
         0:       return vcnt0;
         1:       return vcnt1;
         default: return vcnt2;
      endcase
   endfunction

   initial begin
      int         v0;
      int         drops;
      logic [8:0] d3c;

      // 0xA3 has four ones, so even parity expects a 0 parity bit.
      vecs[0] = '{0, 9'h055, 8, 1'b0, 1'b0, 1, 9'h055, 1'b0, 1'b0};
      vecs[1] = '{0, 9'h080, 8, 1'b0, 1'b0, 1, 9'h080, 1'b0, 1'b0};
      vecs[2] = '{1, 9'h0A3, 8, 1'b1, 1'b0, 1, 9'h0A3, 1'b0, 1'b0};
      vecs[3] = '{1, 9'h0A3, 8, 1'b1, 1'b1, 1, 9'h0A3, 1'b0, 1'b1};

      rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      @(negedge clk);
      check("rst_data", int'(data0), 0);
      check("rst_valid", int'(valid0), 0);
      check("rst_fe", int'(fe0), 0);
      check("rst_pe", int'(pe0), 0);
      check("rst_busy", int'(busy0), 0);
      check("rst_tick", int'(st0), 0);
      check("rst_busy1", int'(busy1), 0);
      check("rst_busy2", int'(busy2), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         v0 = out_vcnt(vecs[i].dut);
         send_frame(vecs[i].dut, vecs[i].data, vecs[i].nbits, vecs[i].has_par,
                    vecs[i].par_bit, vecs[i].nstop, 1'b1);
         hold(vecs[i].dut, 1'b1, 20);
         check($sformatf("vec%0d_valid_count", i), out_vcnt(vecs[i].dut), v0 + 1);
         check($sformatf("vec%0d_data", i), out_data(vecs[i].dut), int'(vecs[i].exp_data));
         check($sformatf("vec%0d_fe", i), out_fe(vecs[i].dut), int'(vecs[i].exp_fe));
         check($sformatf("vec%0d_pe", i), out_pe(vecs[i].dut), int'(vecs[i].exp_pe));
      end

      // Bad stop bit with the line held low afterwards.
      v0 = vcnt0;
      send_frame(0, 9'h0C1, 8, 1'b0, 1'b0, 0, 1'b1);
      drive(0, 1'b0);
      for (int k = 1; k <= T; k++) begin
         @(negedge clk);
         if (k == H) begin
            check("stop_sample_tick", int'(st0), 1);
            check("stop_valid_before", int'(valid0), 0);
            check("stop_fe_before", int'(fe0), 0);
         end
         if (k == H + 1) begin
            check("stop_valid_pulse", int'(valid0), 1);
            check("stop_fe_with_valid", int'(fe0), 1);
            check("stop_data_with_valid", int'(data0), 'hC1);
         end
         if (k == H + 2) check("stop_valid_after", int'(valid0), 0);
      end
      drops = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (busy0 !== 1'b1) drops++;
      end
      check("wait_idle_busy_drops", drops, 0);
      check("bad_stop_valid_count", vcnt0, v0 + 1);
      check("bad_stop_pe", int'(pe0), 0);
      drive(0, 1'b1);
      repeat (2) @(negedge clk);
      check("wait_idle_release_busy", int'(busy0), 0);
      repeat (1000) @(negedge clk);
      check("no_second_frame", vcnt0, v0 + 1);

      // False start: 200-cycle low glitch.
      v0 = vcnt0;
      drive(0, 1'b0);
      for (int k = 1; k <= 440; k++) begin
         @(negedge clk);
         if (k == 200) drive(0, 1'b1);
         if (k == 100) check("glitch_busy_early", int'(busy0), 1);
         if (k == H) begin
            check("glitch_busy_at_sample", int'(busy0), 1);
            check("glitch_sample_tick", int'(st0), 1);
         end
         if (k == H + 2) check("glitch_busy_cleared", int'(busy0), 0);
      end
      check("glitch_no_valid", vcnt0, v0);
      check("glitch_data_kept", int'(data0), 'hC1);
      check("glitch_fe_kept", int'(fe0), 1);

      // Reset in the fourth data bit of 0x3C.
      d3c = 9'h03C;
      v0  = vcnt0;
      hold(0, 1'b0, T);
      for (int i = 0; i < 3; i++) hold(0, d3c[i], T);
      hold(0, d3c[3], 400);
      check("pre_reset_busy", int'(busy0), 1);
      reset_n = 1'b0;
      #1;
      check("mid_reset_data", int'(data0), 0);
      check("mid_reset_valid", int'(valid0), 0);
      check("mid_reset_fe", int'(fe0), 0);
      check("mid_reset_pe", int'(pe0), 0);
      check("mid_reset_busy", int'(busy0), 0);
      check("mid_reset_tick", int'(st0), 0);
      repeat (5) @(negedge clk);
      drive(0, 1'b1);
      reset_n = 1'b1;
      repeat (100) @(negedge clk);
      check("post_reset_idle", int'(busy0), 0);
      check("post_reset_no_valid", vcnt0, v0);
      send_frame(0, d3c, 8, 1'b0, 1'b0, 1, 1'b1);
      hold(0, 1'b1, 20);
      check("post_reset_valid_count", vcnt0, v0 + 1);
      check("post_reset_data", int'(data0), 'h3C);
      check("post_reset_fe", int'(fe0), 0);

      // All-zero 7N2 frame.
      v0 = vcnt2;
      send_frame(2, 9'h000, 7, 1'b0, 1'b0, 2, 1'b0);
      hold(2, 1'b1, 20);
      check("zero7_valid_count", vcnt2, v0 + 1);
      check("zero7_data", int'(data2), 0);
      check("zero7_fe", int'(fe2), 1);
      check("zero7_pe", int'(pe2), 0);
`ifdef UART_RX_GEN_BREAK_DETECT_EN
      check("zero7_break_with_valid", brk_with_valid, 1);
      check("zero7_break_pulses", brk_any, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_gen.md
UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the line rate; TICKS_PER_BIT = CLK_HZ/BAUD (integer division, 868 at defaults) and HALF_TICKS = TICKS_PER_BIT/2.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, meaning the data bits per frame; legal range 5..9, any other value is an elaboration error.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning the parity mode: 0 none, 1 even, 2 odd.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning the stop bits per frame; legal values 1 or 2.
REQ-006 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 The block SHALL have port rx_sync_in  input  1  serial line, already synchronised to clk; idles high.
REQ-009 The block SHALL have port rx_data  output  DATA_BITS  last received word, LSB first on the line.
REQ-010 The block SHALL have port valid  output  1  one-cycle pulse marking a completed frame.
REQ-011 The block SHALL have port frame_error  output  1  set when any stop-bit sample of the last frame was 0.
REQ-012 The block SHALL have port parity_error  output  1  set when the parity check of the last frame failed; constant 0 when PARITY=0.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 The block SHALL have port sample_tick  output  1  one-cycle pulse on every bit-sampling cycle, for debug.

Function
REQ-015 The block SHALL implement the states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; a PARITY=0 build never enters PARITY.
REQ-016 In IDLE, rx_sync_in=0 SHALL load the bit counter and move to START.
REQ-017 START SHALL sample the line after HALF_TICKS cycles: 0 moves to DATA; 1 is a false start and returns to IDLE with no valid and no flag change.
REQ-018 All later samples SHALL occur exactly TICKS_PER_BIT cycles apart; each sample asserts sample_tick for that cycle.
REQ-019 DATA SHALL take DATA_BITS samples LSB-first into a shift register, then move to PARITY (PARITY!=0) or STOP.
REQ-020 PARITY SHALL take one sample; even parity fails if the XOR of data and parity bit is 1, odd parity fails if it is 0.
REQ-021 STOP SHALL take STOP_BITS samples; frame_error is set if any of them is 0.
REQ-022 One cycle after the final stop sample, valid SHALL pulse for exactly one cycle, and rx_data, frame_error and parity_error SHALL update in that same cycle.
REQ-023 rx_data, frame_error and parity_error SHALL hold their values until the next valid.
REQ-024 valid SHALL pulse for every completed frame, including frames with errors.
REQ-025 After the final stop sample, a stop sample of 1 SHALL return to IDLE; a stop sample of 0 SHALL go to WAIT_IDLE, which returns to IDLE only after rx_sync_in=1 is seen.
REQ-026 A falling edge arriving in the cycle the block enters IDLE SHALL start a new frame with no lost cycle.

Reset
REQ-027 reset_n=0 SHALL immediately force IDLE and clear rx_data, valid, frame_error, parity_error, busy, sample_tick, the counters and break_det, including in the middle of a frame.
REQ-028 After reset_n deasserts, the block SHALL not start a frame until it sees rx_sync_in=0 while in IDLE.

Configuration
REQ-029 With macro UART_RX_GEN_BREAK_DETECT_EN defined, the block SHALL add port break_det  output  1, which pulses with valid when all data bits, the parity bit (if any) and the first stop sample were 0.
REQ-030 Without UART_RX_GEN_BREAK_DETECT_EN, the block SHALL have no break_det port and no break logic, and all other behaviour SHALL be unchanged.

Verification (defaults except as noted; 868 cycles per bit)
REQ-031 The bench SHALL send 0x55 with a good stop bit -> valid pulses once, rx_data=0x55, frame_error=0, parity_error=0.
REQ-032 The bench SHALL send 0xC1 with the stop bit held low, then keep the line low 3000 cycles -> valid with frame_error=1, busy stays high until the line rises, and no second frame is seen.
REQ-033 The bench SHALL, with PARITY=1, send 0xA3 with parity bit 0 and then with parity bit 1 -> parity_error=0 for the first frame and 1 for the second.
REQ-034 The bench SHALL pulse rx_sync_in low for 200 cycles -> busy returns to 0 after 434 cycles, no valid, flags unchanged.
REQ-035 The bench SHALL assert reset_n=0 during the fourth data bit of 0x3C -> all outputs 0 at once; after reset releases, sending 0x3C gives rx_data=0x3C.
REQ-036 The bench SHALL, with DATA_BITS=7, STOP_BITS=2 and UART_RX_GEN_BREAK_DETECT_EN defined, send an all-zero frame -> valid, frame_error=1, break_det=1.
